controller_input_manager: RTL
=============================

CONTROLLER_INPUT_MANAGER -- requirements
Module: controller_input_manager

Interface
REQ-001 SHALL have parameter NUM_CONTROLLERS, default 2, number of controllers; legal range 1..4.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16, clk cycles waited after fetch request before capture; legal range 12..255.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port frame_start_i  input  1  single-cycle pulse at start of vblank.
REQ-006 SHALL have port start_fetch_o  output  1  fetch request to the serial controller interface.
REQ-007 SHALL have port data_LIST_i  input  8*NUM_CONTROLLERS  button bytes; controller k occupies bits [8k+7:8k]; 1 = pressed.
REQ-008 SHALL have port rd_en_i  input  1  CPU read strobe.
REQ-009 SHALL have port rd_addr_i  input  4  {controller[1:0], reg[1:0]}.
REQ-010 SHALL have port rd_data_o  output  8  read data.
REQ-011 SHALL have port busy_o  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, REQUEST, SETTLE, CAPTURE.
REQ-013 IDLE: frame_start_i=1 -> REQUEST; otherwise stay.
REQ-014 REQUEST SHALL last exactly 2 cycles with start_fetch_o=1, then -> SETTLE; start_fetch_o SHALL be 0 in every other state.
REQ-015 SETTLE SHALL count SETTLE_CYCLES cycles with an 8-bit down-counter, then -> CAPTURE.
REQ-016 CAPTURE SHALL last 1 cycle, then -> IDLE.
REQ-017 In CAPTURE, per controller k: prev[k]<=cur[k]; cur[k]<=data_LIST_i byte k; pressed[k] |= new & ~cur[k]; released[k] |= ~new & cur[k].
REQ-018 In CAPTURE, frame_valid SHALL be set to 1.
REQ-019 frame_start_i outside IDLE SHALL be ignored for FSM purposes and SHALL set sticky flag overrun.
REQ-020 Register map per controller: reg0 = cur, reg1 = pressed, reg2 = released, reg3 = status {busy, 5'b0, overrun, frame_valid} (bit7..bit0).
REQ-021 Status SHALL read identically at every controller index.
REQ-022 Reads SHALL have 1-cycle latency: rd_data_o registered on the cycle after rd_en_i; rd_data_o holds its value when rd_en_i=0.
REQ-023 A controller index >= NUM_CONTROLLERS SHALL read 8'h00 for reg0..reg2.
REQ-024 Reading reg1 or reg2 SHALL clear that register after returning its pre-clear value.
REQ-025 Same-cycle read-clear and CAPTURE-set on one register: register SHALL become the newly set edge bits only; old bits are cleared.
REQ-026 Reading status SHALL clear overrun.
REQ-027 Same-cycle status read and new overrun: overrun SHALL stay 1.
REQ-028 busy_o SHALL be combinational from the FSM state.

Reset
REQ-029 On rst: FSM -> IDLE; counter=0; cur, prev, pressed, released = 0; frame_valid=0; overrun=0; start_fetch_o=0; rd_data_o=8'h00.
REQ-030 rst asserted mid-REQUEST or mid-SETTLE SHALL abort with no capture, and start_fetch_o SHALL be 0 on the next cycle.

Verification
REQ-031 rst, then a frame_start pulse -> start_fetch_o high for exactly 2 cycles; CAPTURE occurs 1+2+16 cycles after the pulse; busy_o high throughout.
REQ-032 Data 8'h00 on frame 1 and 8'h81 on frame 2, controller 0 -> reg0=8'h81, reg1=8'h81, reg2=8'h00; a second read of reg1 returns 8'h00.
REQ-033 Controller 1: 8'hFF then 8'h0F -> reg2 (addr 4'h6) = 8'hF0; reg0 (addr 4'h4) = 8'h0F.
REQ-034 frame_start pulsed during SETTLE -> no second fetch; status=8'h83 while busy, 8'h01 after idle; overrun reads 0 on the following status read.
REQ-035 reg1 read in the same cycle as a CAPTURE adding bit 2 -> returns the old value; the next read returns 8'h04.
REQ-036 rst during SETTLE, with data changed -> cur unchanged at 0, frame_valid=0, FSM IDLE; addr 4'hC reads 8'h00 with NUM_CONTROLLERS=2.

Source files
------------

// File: rtl/controller_input_manager.sv
// Controller input manager: once per frame it requests a fetch from the serial
// controller interface, waits for the data to settle, and captures the button
// bytes. Each controller keeps its current state plus sticky pressed and
// released edge bits. The CPU reads these through a small register map with
// one cycle of latency.
module controller_input_manager #(
    parameter int NUM_CONTROLLERS = 2,
    parameter int SETTLE_CYCLES   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_start_i,
    output logic                         start_fetch_o,
    input  logic [8*NUM_CONTROLLERS-1:0] data_LIST_i,
    input  logic                         rd_en_i,
    input  logic [3:0]                   rd_addr_i,
    output logic [7:0]                   rd_data_o,
    output logic                         busy_o
);

    typedef enum logic [1:0] {IDLE, REQUEST, SETTLE, CAPTURE} state_t;

    // The down-counter is loaded with N-1, so each timed state lasts N cycles.
    localparam logic [7:0] REQ_LOAD    = 8'd1;
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       start_fetch_q;

    logic [NUM_CONTROLLERS-1:0][7:0] cur_q, cur_d;
    logic [NUM_CONTROLLERS-1:0][7:0] prev_q, prev_d;
    logic [NUM_CONTROLLERS-1:0][7:0] pressed_q, pressed_d;
    logic [NUM_CONTROLLERS-1:0][7:0] released_q, released_d;
    logic       frame_valid_q, frame_valid_d;
    logic       overrun_q, overrun_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [7:0] rd_val;

    logic       capture;
    logic       busy;
    logic [1:0] rd_ctrl;
    logic [1:0] rd_reg;
    logic       status_rd;

    // The previous-frame snapshot is not on the read map. It is kept so the
    // value can be probed during bring-up.
    logic unused_prev;
    assign unused_prev = ^prev_q;

    assign capture       = (state_q == CAPTURE);
    assign busy          = (state_q != IDLE);
    assign busy_o        = busy;
    assign start_fetch_o = start_fetch_q;
    assign rd_data_o     = rd_data_q;
    assign rd_ctrl       = rd_addr_i[3:2];
    assign rd_reg        = rd_addr_i[1:0];
    assign status_rd     = rd_en_i && (rd_reg == 2'd3);

    // Frame sequencer: IDLE -> REQUEST(2) -> SETTLE(N) -> CAPTURE(1) -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            start_fetch_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        state_q       <= REQUEST;
                        cnt_q         <= REQ_LOAD;
                        start_fetch_q <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (cnt_q == 8'd0) begin
                        state_q       <= SETTLE;
                        cnt_q         <= SETTLE_LOAD;
                        start_fetch_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) state_q <= CAPTURE;
                    else               cnt_q   <= cnt_q - 8'd1;
                end
                CAPTURE: state_q <= IDLE;
                default: begin
                    state_q       <= IDLE;
                    start_fetch_q <= 1'b0;
                end
            endcase
        end
    end

    // Next state of the per-controller registers. A read-clear and a capture in
    // the same cycle keep only the newly captured edges.
    always_comb begin
        cur_d      = cur_q;
        prev_d     = prev_q;
        pressed_d  = pressed_q;
        released_d = released_q;
        for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            if (rd_en_i && rd_ctrl == 2'(k) && rd_reg == 2'd1) pressed_d[k]  = 8'h00;
            if (rd_en_i && rd_ctrl == 2'(k) && rd_reg == 2'd2) released_d[k] = 8'h00;
            if (capture) begin
                prev_d[k]     = cur_q[k];
                cur_d[k]      = data_LIST_i[8*k +: 8];
                pressed_d[k]  = pressed_d[k]  | (data_LIST_i[8*k +: 8] & ~cur_q[k]);
                released_d[k] = released_d[k] | (~data_LIST_i[8*k +: 8] & cur_q[k]);
            end
        end
        frame_valid_d = frame_valid_q | capture;
        // A new overrun takes priority over the clear caused by a status read.
        overrun_d     = (status_rd ? 1'b0 : overrun_q) | (frame_start_i & busy);
    end

    // Read mux. Status is the same at every index, and absent controllers read 0.
    always_comb begin
        rd_val = 8'h00;
        if (rd_reg == 2'd3) begin
            rd_val = {busy, 5'b0, overrun_q, frame_valid_q};
        end else begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                if (rd_ctrl == 2'(k)) begin
                    case (rd_reg)
                        2'd0:    rd_val = cur_q[k];
                        2'd1:    rd_val = pressed_q[k];
                        2'd2:    rd_val = released_q[k];
                        default: rd_val = 8'h00;
                    endcase
                end
            end
        end
        rd_data_d = rd_en_i ? rd_val : rd_data_q;
    end

    // Controller state, sticky flags and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q         <= '0;
            prev_q        <= '0;
            pressed_q     <= '0;
            released_q    <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
            rd_data_q     <= 8'h00;
        end else begin
            cur_q         <= cur_d;
            prev_q        <= prev_d;
            pressed_q     <= pressed_d;
            released_q    <= released_d;
            frame_valid_q <= frame_valid_d;
            overrun_q     <= overrun_d;
            rd_data_q     <= rd_data_d;
        end
    end

endmodule
